// File: rtl/alloc_port.sv
// Client front-end for the linked-memory allocator: queues rd/wr/alloc/free requests,
// range-checks them, issues one op per cycle and returns in-order responses.
module alloc_port #(
  parameter int          REQ_DEPTH = 4,
  parameter int          RSP_DEPTH = 4,
  parameter logic [15:0] BASE      = 16'h5000,
  parameter int          RAM_SIZE  = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_req_op,
  input  logic [15:0] i_req_addr,
  input  logic [15:0] i_req_data,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [15:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_idle,
  output logic        o_al,
  output logic [15:0] o_adata,
  output logic        o_fr,
  output logic [15:0] o_faddr,
  output logic        o_wr,
  output logic [15:0] o_waddr,
  output logic [15:0] o_wdata,
  output logic        o_rd,
  output logic [15:0] o_raddr,
  input  logic [15:0] i_aaddr,
  input  logic [15:0] i_rdata
);

  typedef enum logic [1:0] {
    OP_RD = 2'b00,
    OP_WR = 2'b01,
    OP_AL = 2'b10,
    OP_FR = 2'b11
  } op_e;

  typedef struct packed {
    op_e         op;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic        vld;
    op_e         op;
    logic        err;
    logic [15:0] addr;
  } flight_t;

  localparam int QAW = $clog2(REQ_DEPTH);
  localparam int SAW = $clog2(RSP_DEPTH);
  localparam int QCW = QAW + 1;
  localparam int SCW = SAW + 2;
  localparam logic [QCW-1:0] REQ_FULL    = QCW'(REQ_DEPTH);
  localparam logic [SCW-1:0] RSP_CREDITS = SCW'(RSP_DEPTH);
  localparam logic [16:0]    ADDR_LO     = {1'b0, BASE};
  localparam logic [16:0]    ADDR_HI     = ADDR_LO + 17'(RAM_SIZE);

  // ---------------- request FIFO ----------------
  req_t           req_mem [REQ_DEPTH];
  logic [QAW-1:0] req_wr_ptr, req_rd_ptr;
  logic [QCW-1:0] req_count;
  logic           req_accept;
  req_t           head;

  // ---------------- in-flight / response FIFO ----------------
  flight_t        flight;
  rsp_t           rsp_mem [RSP_DEPTH];
  logic [SAW-1:0] rsp_wr_ptr, rsp_rd_ptr;
  logic [SAW:0]   rsp_count;
  logic           rsp_push, rsp_pop;
  rsp_t           rsp_in;

  logic           in_range, head_err, credit_ok, issue;
  logic [SCW-1:0] credits_used;

  assign o_req_ready = (req_count < REQ_FULL);
  assign req_accept  = i_req_valid && o_req_ready;
  assign head        = req_mem[req_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_wr_ptr <= '0;
      req_rd_ptr <= '0;
      req_count  <= '0;
    end else begin
      if (req_accept) req_wr_ptr <= req_wr_ptr + 1'b1;
      if (issue)      req_rd_ptr <= req_rd_ptr + 1'b1;
      case ({req_accept, issue})
        2'b10:   req_count <= req_count + 1'b1;
        2'b01:   req_count <= req_count - 1'b1;
        default: req_count <= req_count;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; validity comes from the reset counters, and
  // leaving the array out of the reset lets it map onto plain RAM/flops.
  always_ff @(posedge i_clk) begin
    if (req_accept) req_mem[req_wr_ptr] <= '{op: op_e'(i_req_op), addr: i_req_addr, data: i_req_data};
  end

  // Credit rule: every issued op already owns a response slot, so capture never overflows.
  assign credits_used = SCW'(rsp_count) + SCW'(flight.vld);
  assign credit_ok    = (credits_used < RSP_CREDITS);
  assign issue        = (req_count != '0) && credit_ok;

  assign in_range = ({1'b0, head.addr} >= ADDR_LO) && ({1'b0, head.addr} < ADDR_HI);
  assign head_err = (head.op != OP_AL) && !in_range;

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    o_rd    = 1'b0;
    o_wr    = 1'b0;
    o_al    = 1'b0;
    o_fr    = 1'b0;
    o_raddr = '0;
    o_waddr = '0;
    o_wdata = '0;
    o_adata = '0;
    o_faddr = '0;
    if (issue && !head_err) begin
      unique case (head.op)
        OP_RD: begin o_rd = 1'b1; o_raddr = head.addr; end
        OP_WR: begin o_wr = 1'b1; o_waddr = head.addr; o_wdata = head.data; end
        OP_AL: begin o_al = 1'b1; o_adata = head.data; end
        OP_FR: begin o_fr = 1'b1; o_faddr = head.addr; end
      endcase
    end
  end

  // Rejected ops still travel through the in-flight stage to keep responses in order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      flight <= '0;
    end else begin
      flight.vld <= issue;
      if (issue) begin
        flight.op   <= head.op;
        flight.err  <= head_err;
        flight.addr <= head.addr;
      end
    end
  end

  always_comb begin
    rsp_in     = '0;
    rsp_in.err = flight.err;
    if (!flight.err) begin
      unique case (flight.op)
        OP_RD:   rsp_in.data = i_rdata;
        OP_AL:   rsp_in.data = i_aaddr;
        default: rsp_in.data = flight.addr;
      endcase
    end
  end

  assign rsp_push = flight.vld;
  assign rsp_pop  = o_rsp_valid && i_rsp_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_count  <= '0;
    end else begin
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_count <= rsp_count + 1'b1;
        2'b01:   rsp_count <= rsp_count - 1'b1;
        default: rsp_count <= rsp_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (rsp_push) rsp_mem[rsp_wr_ptr] <= rsp_in;
  end

  // Head fields are gated so the outputs read zero whenever no response is presented.
  assign o_rsp_valid = (rsp_count != '0);
  assign o_rsp_data  = o_rsp_valid ? rsp_mem[rsp_rd_ptr].data : 16'h0000;
  assign o_rsp_err   = o_rsp_valid ? rsp_mem[rsp_rd_ptr].err  : 1'b0;
  assign o_idle      = (req_count == '0) && (rsp_count == '0) && !flight.vld;

endmodule

// File: tb/tb_alloc_port.sv
// Self-checking bench for alloc_port: behavioural allocator environment plus an
// accept-time reference model of the expected response stream.
module tb_alloc_port;

  localparam logic [15:0] BASE      = 16'h5000;
  localparam int          RAM_SIZE  = 256;
  localparam int          REQ_DEPTH = 4;
  localparam int          RSP_DEPTH = 4;
  localparam logic [1:0]  RD = 2'b00, WR = 2'b01, AL = 2'b10, FR = 2'b11;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } rsp_t;

  logic        clk, rst_n;
  logic        i_req_valid, o_req_ready;
  logic [1:0]  i_req_op;
  logic [15:0] i_req_addr, i_req_data;
  logic        o_rsp_valid, i_rsp_ready, o_rsp_err, o_idle;
  logic [15:0] o_rsp_data;
  logic        o_al, o_fr, o_wr, o_rd;
  logic [15:0] o_adata, o_faddr, o_waddr, o_wdata, o_raddr;
  logic [15:0] i_aaddr, i_rdata;

  alloc_port #(
    .REQ_DEPTH(REQ_DEPTH), .RSP_DEPTH(RSP_DEPTH), .BASE(BASE), .RAM_SIZE(RAM_SIZE)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_op(i_req_op),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_rsp_err(o_rsp_err), .o_idle(o_idle),
    .o_al(o_al), .o_adata(o_adata), .o_fr(o_fr), .o_faddr(o_faddr),
    .o_wr(o_wr), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_rd(o_rd), .o_raddr(o_raddr),
    .i_aaddr(i_aaddr), .i_rdata(i_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic bit in_rng(input logic [15:0] a);
    return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + RAM_SIZE);
  endfunction

  function automatic int idx(input logic [15:0] a);
    return int'(a) - int'(BASE);
  endfunction

  // ---------------- allocator environment (acts on DUT strobes) ----------------
  logic [15:0] env_mem [RAM_SIZE];
  logic [15:0] env_free [$];
  int n_rd = 0, n_wr = 0, n_al = 0, n_fr = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_rd | o_wr | o_al | o_fr) check("strobe_onehot", $countones({o_rd, o_wr, o_al, o_fr}), 1);
    if (o_rd) begin
      n_rd++;
      check("rd_addr_range", in_rng(o_raddr), 1);
      if (in_rng(o_raddr)) i_rdata <= env_mem[idx(o_raddr)];
    end
    if (o_wr) begin
      n_wr++;
      check("wr_addr_range", in_rng(o_waddr), 1);
      if (in_rng(o_waddr)) env_mem[idx(o_waddr)] = o_wdata;
    end
    if (o_al) begin
      logic [15:0] a;
      n_al++;
      a = env_free.pop_front();
      env_mem[idx(a)] = o_adata;
      i_aaddr <= a;
    end
    if (o_fr) begin
      n_fr++;
      check("fr_addr_range", in_rng(o_faddr), 1);
      env_free.push_front(o_faddr);
    end
  end

  // ---------------- reference model (evaluated at acceptance) ----------------
  logic [15:0] ref_mem [RAM_SIZE];
  logic [15:0] ref_free [$];
  rsp_t        exp_q [$];
  rsp_t        rsp_log [$];

  task automatic ref_accept(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data);
    rsp_t r;
    r.err  = 1'b0;
    r.data = addr;
    if (op != AL && !in_rng(addr)) begin
      r.err  = 1'b1;
      r.data = 16'h0000;
    end else begin
      case (op)
        RD: r.data = ref_mem[idx(addr)];
        WR: ref_mem[idx(addr)] = data;
        AL: begin
          r.data = ref_free.pop_front();
          ref_mem[idx(r.data)] = data;
        end
        default: ref_free.push_front(addr);
      endcase
    end
    exp_q.push_back(r);
  endtask

  // ---------------- response monitor ----------------
  bit seen_valid = 0;
  int first_cyc  = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_rsp_valid && !seen_valid) begin
        seen_valid = 1;
        first_cyc  = cyc;
      end
      if (o_rsp_valid && i_rsp_ready) begin
        rsp_t got, e;
        got.data = o_rsp_data;
        got.err  = o_rsp_err;
        rsp_log.push_back(got);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL rsp_unexpected: got %h/%b want none", got.data, got.err);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", got.data, e.data);
          check("rsp_err", got.err, e.err);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic try_send(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data,
                          output bit ok);
    i_req_valid = 1'b1;
    i_req_op    = op;
    i_req_addr  = addr;
    i_req_data  = data;
    @(negedge clk);
    ok = o_req_ready;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    if (ok) ref_accept(op, addr, data);
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data);
    bit ok;
    for (int k = 0; k < 50; k++) begin
      try_send(op, addr, data, ok);
      if (ok) return;
      i_rsp_ready = 1'b1;
    end
    total++;
    bad++;
    $error("FAIL send_timeout: got no accept want accept within 50 cycles");
  endtask

  task automatic drain(input string tag);
    i_rsp_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && o_idle) break;
    end
    check({tag, "_idle"}, o_idle, 1);
    check({tag, "_pending"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic resync();
    exp_q.delete();
    ref_free.delete();
    foreach (env_free[i]) ref_free.push_back(env_free[i]);
    foreach (env_mem[i]) ref_mem[i] = env_mem[i];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0] want1 [4];
    logic [15:0] want2 [5];
    int e0, snap_rd, snap_wr, snap_fr, acc, nlog, nops;
    bit ok;

    want1 = '{16'h50FF, 16'h5095, 16'hBE11, 16'hC0DE};
    want2 = '{16'h5000, 16'h5001, 16'h5002, 16'h5001, 16'h5001};
    for (int i = 0; i < RAM_SIZE; i++) begin
      env_mem[i] = 16'h0000;
      ref_mem[i] = 16'h0000;
      env_free.push_back(BASE + 16'(i));
      ref_free.push_back(BASE + 16'(i));
    end
    i_req_valid = 0; i_req_op = 0; i_req_addr = 0; i_req_data = 0;
    i_rsp_ready = 1; i_aaddr = 0; i_rdata = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_req_ready", o_req_ready, 1);
    check("rst_rsp_valid", o_rsp_valid, 0);
    check("rst_rsp_data", o_rsp_data, 16'h0000);
    check("rst_rsp_err", o_rsp_err, 0);
    check("rst_idle", o_idle, 1);
    check("rst_strobes", {o_rd, o_wr, o_al, o_fr}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: write/write/read/read with latency check
    seen_valid = 0;
    rsp_log.delete();
    send(WR, 16'h50FF, 16'hBE11);
    e0 = cyc;
    send(WR, 16'h5095, 16'hC0DE);
    send(RD, 16'h50FF, 16'h0000);
    send(RD, 16'h5095, 16'h0000);
    drain("t1");
    check("t1_latency", first_cyc - e0, 2);
    check("t1_count", rsp_log.size(), 4);
    for (int i = 0; i < 4 && i < rsp_log.size(); i++) begin
      check("t1_data", rsp_log[i].data, want1[i]);
      check("t1_err", rsp_log[i].err, 0);
    end

    // 2: alloc x3, free, realloc
    rsp_log.delete();
    send(AL, 16'h0000, 16'hFADE);
    send(AL, 16'h0000, 16'hAB1E);
    send(AL, 16'h0000, 16'hB055);
    drain("t2a");
    send(FR, 16'h5001, 16'h0000);
    send(AL, 16'h0000, 16'hDEAF);
    drain("t2b");
    check("t2_count", rsp_log.size(), 5);
    for (int i = 0; i < 5 && i < rsp_log.size(); i++) check("t2_data", rsp_log[i].data, want2[i]);

    // 3: out-of-range requests
    rsp_log.delete();
    snap_rd = n_rd; snap_wr = n_wr; snap_fr = n_fr;
    send(FR, 16'h0001, 16'h0000);
    send(RD, 16'h5100, 16'h0000);
    send(WR, 16'h4FFF, 16'h1234);
    drain("t3");
    check("t3_no_rd", n_rd - snap_rd, 0);
    check("t3_no_wr", n_wr - snap_wr, 0);
    check("t3_no_fr", n_fr - snap_fr, 0);
    check("t3_count", rsp_log.size(), 3);
    for (int i = 0; i < 3 && i < rsp_log.size(); i++) begin
      check("t3_err", rsp_log[i].err, 1);
      check("t3_data", rsp_log[i].data, 16'h0000);
    end

    // 4: backpressure; keep offering reads of 5000 until the request queue refuses
    rsp_log.delete();
    i_rsp_ready = 1'b0;
    snap_rd = n_rd;
    acc = 0;
    for (int k = 0; k < 16; k++) begin
      try_send(RD, 16'h5000, 16'h0000, ok);
      if (!ok) break;
      acc++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("t4_accepted", acc, REQ_DEPTH + RSP_DEPTH);
    check("t4_req_ready", o_req_ready, 0);
    check("t4_strobes", n_rd - snap_rd, RSP_DEPTH);
    check("t4_rsp_valid", o_rsp_valid, 1);
    drain("t4");
    check("t4_count", rsp_log.size(), REQ_DEPTH + RSP_DEPTH);
    foreach (rsp_log[i]) check("t4_data", rsp_log[i].data, 16'hFADE);

    // 5: reset while an alloc strobe is up
    nlog = rsp_log.size();
    send(AL, 16'h0000, 16'h1234);
    check("t5_al_up", o_al, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_al_drop", o_al, 0);
    check("t5_adata", o_adata, 16'h0000);
    check("t5_req_ready", o_req_ready, 1);
    check("t5_rsp_valid", o_rsp_valid, 0);
    check("t5_rsp_data", o_rsp_data, 16'h0000);
    check("t5_idle", o_idle, 1);
    resync();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t5_idle_after", o_idle, 1);
    check("t5_no_stale", rsp_log.size(), nlog);

    // 6: random ops, first back-to-back with full drain rate, then with random backpressure
    rsp_log.delete();
    nops = 0;
    for (int k = 0; k < 60; k++) begin
      logic [1:0]  op;
      logic [15:0] addr;
      op   = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 3) == 0) ? 16'($urandom()) : BASE + 16'($urandom_range(0, RAM_SIZE - 1));
      i_rsp_ready = (k < 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
      send(op, addr, 16'($urandom()));
      nops++;
    end
    drain("t6");
    check("t6_count", rsp_log.size(), nops);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
